// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues word fetches to a synchronous
// instruction memory and buffers returned words with their PC+4 for decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc_plus4,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pcp4_mem  [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   demand;

  always_comb begin
    pop    = (count_q != '0) && id_ready;
    push   = inflight_q && !redirect_valid;
    // Entries held plus the response still due, less what leaves this cycle.
    demand = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue  = rst_n && !redirect_valid && (demand < (CW+1)'(DEPTH));

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is not reset; the empty-FIFO mux below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wptr_q] <= imem_rdata;
      pcp4_mem[wptr_q]  <= inflight_pc_q + 32'd4;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != '0);
  assign id_instr    = id_valid ? instr_mem[rptr_q] : 32'd0;
  assign id_pc_plus4 = id_valid ? pcp4_mem[rptr_q]  : 32'd0;
  assign occupancy   = count_q;

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && count_q == CW'(DEPTH)));

endmodule
